uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side partner of the team's UART transmitter. Both blocks use the same bit timing: 434 clocks per bit by default.
- Takes the asynchronous serial line, synchronises it, and detects and validates the start bit.
- Samples 8 data bits LSB-first at mid-bit, then checks the stop bit.
- Presents the received byte with a one-cycle DONE strobe, or flags a framing error. Sits between the board RX pin and the byte-level consumer logic.

Parameters:
CLKS_PER_BIT, 434, clocks per serial bit; must be >= 8; the transmitter uses 434.
SYNC_STAGES, 2, flip-flop stages on RX_IN before use; must be >= 2.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  reset: one clock; synchronous, active-low.
RX_IN  input  1  asynchronous serial line, idle high.
RX_OUT  output  8  last correctly received byte.
DONE  output  1  one-cycle pulse: a new byte is on RX_OUT.
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
BUSY  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - RX_OUT=8'h00, DONE=0, FRAME_ERR=0, BUSY=0.
  - State=IDLE, counters=0, synchroniser flops=1.
  - Reset mid-frame aborts the frame silently: no DONE, no FRAME_ERR.
- Synchroniser: RX_IN passes through SYNC_STAGES flops to give RX_S. All decisions use RX_S only.
- Internal values: HALF = CLKS_PER_BIT/2 (integer division). Clock counter is wide enough for CLKS_PER_BIT-1. Bit index is 3 bits. Shift register is 8 bits.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_IDLE. Unknown state encodings go to IDLE.
- IDLE:
  - BUSY=0, counter held at 0.
  - RX_S==0 in a cycle: go to START_BIT, BUSY=1 from the next cycle.
- START_BIT:
  - Counter increments each cycle.
  - At counter==HALF-1, sample RX_S:
    - 0: valid start. Go to DATA_BITS, counter=0, bit index=0.
    - 1: glitch. Go to IDLE, BUSY drops; no DONE or FRAME_ERR.
- DATA_BITS:
  - At counter==CLKS_PER_BIT-1: shift RX_S into bit[bit index] (LSB first), counter=0.
  - Bit index 7 goes to STOP_BIT; otherwise bit index +1.
  - Each sample therefore lands at mid-bit.
- STOP_BIT: at counter==CLKS_PER_BIT-1, sample RX_S:
  - 1: RX_OUT <= shift register, DONE=1 for exactly one cycle, go to IDLE.
  - 0: FRAME_ERR=1 for one cycle, RX_OUT unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - BUSY stays 1. Stays in this state while RX_S==0, so a break condition is one error, not repeated frames.
  - First cycle with RX_S==1 goes to IDLE.
- DONE and FRAME_ERR are never high in the same cycle. Neither pulses outside the STOP_BIT exit.
- RX_OUT changes only on the DONE cycle and holds otherwise.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start edge, half a bit later, be caught. Zero idle time between frames must work.
- Latency: DONE is asserted (HALF + 9*CLKS_PER_BIT) cycles after the first IDLE cycle with RX_S==0, ±1 cycle for implementation alignment. The exact value is fixed by the bench against the RTL.
- Tolerance: receives correctly with transmitter bit period off by ±3%.

Test Plan:
- CLKS_PER_BIT=16: reset, then drive frame 0x55 (start, 1,0,1,0,1,0,1,0, stop) -> exactly one DONE pulse; RX_OUT=8'h55; FRAME_ERR never high; BUSY back to 0 after the stop sample.
- Two back-to-back frames 0xA5 then 0x3C with zero idle bits -> two DONE pulses 10*16 cycles apart; RX_OUT=8'hA5 then 8'h3C.
- Low glitch of 4 clocks on idle line -> BUSY pulses high, returns to 0 at the start-bit check; no DONE, no FRAME_ERR; RX_OUT unchanged.
- Frame 0xF0 with stop bit driven 0, line held low 40 more clocks, then high -> one FRAME_ERR pulse; RX_OUT keeps its previous value; BUSY stays 1 until the line goes high; the next valid frame 0x81 gives DONE with RX_OUT=8'h81.
- RST_N driven low for 1 cycle at data bit 4 of a frame -> all outputs reset next edge (RX_OUT=8'h00); no DONE from the aborted frame; a following clean frame 0x7E is received.
- CLKS_PER_BIT=434: loop the team's UART transmitter (TX_IN=8'hC3, START pulse) into RX_IN -> DONE with RX_OUT=8'hC3, no FRAME_ERR.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises RX_IN, validates the start bit at mid-bit,
// samples eight data bits LSB-first and checks the stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX_IN,
  output logic [7:0] RX_OUT,
  output logic       DONE,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic [7:0]             shift_reg, shift_next;
  logic [7:0]             rx_out_reg, rx_out_next;
  logic                   done_reg, done_next;
  logic                   ferr_reg, ferr_next;
  logic                   rx_s;

  assign rx_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_reg    <= '1;
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      rx_out_reg  <= '0;
      done_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], RX_IN};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      rx_out_reg  <= rx_out_next;
      done_reg    <= done_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    rx_out_next  = rx_out_reg;
    done_next    = 1'b0;
    ferr_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_reg == HALF_M1) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_reg == LAST) begin
          cnt_next                = '0;
          shift_next[bit_idx_reg] = rx_s;
          if (bit_idx_reg == 3'd7) state_next = S_STOP;
          else bit_idx_next = bit_idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (cnt_reg == LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            rx_out_next = shift_reg;
            done_next   = 1'b1;
            state_next  = S_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = S_WAIT;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_WAIT: begin
        cnt_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    BUSY      = (state_reg != S_IDLE);
    DONE      = done_reg;
    FRAME_ERR = ferr_reg;
    RX_OUT    = rx_out_reg;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16-clock/bit instance for protocol cases and a
// 434-clock/bit instance fed by a behavioural transmitter.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx16 = 1'b1;
  logic       rx434 = 1'b1;
  logic [7:0] rx_out16, rx_out434;
  logic       done16, done434, ferr16, ferr434, busy16, busy434;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int done_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  int done434_cnt = 0, ferr434_cnt = 0;
  bit busy_seen = 1'b0;
  int done_cyc[8];
  logic [7:0] done_byte[8];
  logic [7:0] byte434 = 8'h00;
  int t_drive;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_dut (
    .CLK(clk), .RST_N(rst_n), .RX_IN(rx16), .RX_OUT(rx_out16),
    .DONE(done16), .FRAME_ERR(ferr16), .BUSY(busy16)
  );

  uart_rx #(.CLKS_PER_BIT(434), .SYNC_STAGES(2)) u_dut434 (
    .CLK(clk), .RST_N(rst_n), .RX_IN(rx434), .RX_OUT(rx_out434),
    .DONE(done434), .FRAME_ERR(ferr434), .BUSY(busy434)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy16) busy_seen = 1'b1;
    if (done16) begin
      done_cyc[done_cnt & 7]  = cyc;
      done_byte[done_cnt & 7] = rx_out16;
      done_cnt++;
    end
    if (ferr16) ferr_cnt++;
    if (done16 && ferr16) both_cnt++;
    if (done434) begin
      byte434 = rx_out434;
      done434_cnt++;
    end
    if (ferr434) ferr434_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx434 = v;
    else rx16 = v;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int per, input bit sel);
    drive(sel, 1'b0);
    t_drive = cyc;
    idle(per);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      idle(per);
    end
    drive(sel, stop);
    idle(per);
  endtask

  task automatic clear_counts();
    done_cnt  = 0;
    ferr_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  initial begin
    int t0;
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    check("reset_rx_out", rx_out16, 8'h00);
    check("reset_done", done16, 1'b0);
    check("reset_ferr", ferr16, 1'b0);
    check("reset_busy", busy16, 1'b0);
    rst_n = 1'b1;
    idle(20);

    // Single frame 0x55; DONE expected 155 edges after the start edge is driven
    // (2 sync + 1 detect + HALF + 9*16).
    clear_counts();
    send_frame(8'h55, 1'b1, 16, 1'b0);
    t0 = t_drive;
    idle(4);
    check("f55_done_cnt", done_cnt, 1);
    check("f55_ferr_cnt", ferr_cnt, 0);
    check("f55_byte", done_byte[0], 8'h55);
    check("f55_rx_out", rx_out16, 8'h55);
    check("f55_latency", done_cyc[0] - t0, 155);
    check("f55_busy_seen", busy_seen, 1'b1);
    check("f55_busy_after", busy16, 1'b0);

    // Back-to-back frames, no idle bits between them.
    clear_counts();
    send_frame(8'hA5, 1'b1, 16, 1'b0);
    send_frame(8'h3C, 1'b1, 16, 1'b0);
    idle(4);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_byte0", done_byte[0], 8'hA5);
    check("b2b_byte1", done_byte[1], 8'h3C);
    check("b2b_spacing", done_cyc[1] - done_cyc[0], 160);
    check("b2b_ferr_cnt", ferr_cnt, 0);
    check("b2b_both", both_cnt, 0);

    // Four-clock glitch on the idle line.
    clear_counts();
    rx16 = 1'b0;
    idle(4);
    rx16 = 1'b1;
    idle(20);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_after", busy16, 1'b0);
    check("glitch_done_cnt", done_cnt, 0);
    check("glitch_ferr_cnt", ferr_cnt, 0);
    check("glitch_rx_out", rx_out16, 8'h3C);

    // Framing error followed by a held-low line, then recovery.
    clear_counts();
    send_frame(8'hF0, 1'b0, 16, 1'b0);
    idle(40);
    check("ferr_busy_held", busy16, 1'b1);
    check("ferr_cnt", ferr_cnt, 1);
    check("ferr_done_cnt", done_cnt, 0);
    check("ferr_rx_out_kept", rx_out16, 8'h3C);
    rx16 = 1'b1;
    idle(4);
    check("ferr_busy_release", busy16, 1'b0);
    idle(10);
    clear_counts();
    send_frame(8'h81, 1'b1, 16, 1'b0);
    idle(4);
    check("recover_done_cnt", done_cnt, 1);
    check("recover_rx_out", rx_out16, 8'h81);
    check("recover_ferr_cnt", ferr_cnt, 0);

    // Reset in the middle of data bit 4 of 0xF3; remaining bits are all high.
    clear_counts();
    rx16 = 1'b0;
    idle(16);
    rx16 = 1'b1; idle(16);
    rx16 = 1'b1; idle(16);
    rx16 = 1'b0; idle(16);
    rx16 = 1'b0; idle(16);
    rx16 = 1'b1;
    idle(8);
    rst_n = 1'b0;
    idle(1);
    check("midrst_rx_out", rx_out16, 8'h00);
    check("midrst_busy", busy16, 1'b0);
    check("midrst_done", done16, 1'b0);
    rst_n = 1'b1;
    idle(8 + 3 * 16 + 16 + 10);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_ferr", ferr_cnt, 0);
    check("midrst_rx_out_hold", rx_out16, 8'h00);
    send_frame(8'h7E, 1'b1, 16, 1'b0);
    idle(4);
    check("post_rst_done_cnt", done_cnt, 1);
    check("post_rst_rx_out", rx_out16, 8'h7E);

    // Full-rate instance: nominal, +3% and -3% transmitter bit periods.
    idle(20);
    send_frame(8'hC3, 1'b1, 434, 1'b1);
    idle(20);
    check("tx434_done_cnt", done434_cnt, 1);
    check("tx434_rx_out", byte434, 8'hC3);
    check("tx434_ferr_cnt", ferr434_cnt, 0);
    send_frame(8'h5A, 1'b1, 447, 1'b1);
    idle(20);
    check("tx434_slow_done_cnt", done434_cnt, 2);
    check("tx434_slow_rx_out", byte434, 8'h5A);
    send_frame(8'hA6, 1'b1, 421, 1'b1);
    idle(20);
    check("tx434_fast_done_cnt", done434_cnt, 3);
    check("tx434_fast_rx_out", byte434, 8'hA6);
    check("tx434_fast_ferr_cnt", ferr434_cnt, 0);
    check("tx434_busy_after", busy434, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
